atc_e_stage: RTL and testbench
==============================

# atc_e_stage

Decode-to-execute attribute stage and hazard controller for the five-stage MIPS pipeline. It registers the register-address and result-type attributes of the instruction leaving D into E, and feeds them to the E→M attribute register. It compares the D-stage instruction's read addresses and use-times against the E and M attributes (M fed back from the downstream stage), and issues a pipeline stall with bubble insertion. It also owns the multiply/divide busy counter that stalls HI/LO-dependent instructions.

## Interface
Parameters:
- MULT_CYC, 5, multiply latency in cycles after issue
- DIV_CYC, 10, divide latency in cycles after issue

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- ra1D  input  5  rs address of D instruction
- ra2D  input  5  rt address of D instruction
- waD  input  5  destination address of D instruction
- resD  input  3  result type of D instruction: 0 NW (no write), 1 ALU, 2 DM (load), 3 PC (link), 4 MD (mfhi/mflo)
- tuse1D  input  2  cycles until rs is needed: 0, 1, or 3 = not used
- tuse2D  input  2  same for rt
- mdD  input  2  MD start: 0 none, 1 mult/multu, 2 div/divu
- mduseD  input  1  D instruction touches HI/LO or the MDU (mult, div, mfhi, mflo, mthi, mtlo)
- waM, resM  input  5, 3  attributes currently in M (from the E→M register)
- ra1E, ra2E, waE  output  5  registered attributes of E instruction
- resE  output  3  registered result type of E instruction
- stall  output  1  combinational; freeze PC and D register
- busy  output  1  MDU busy

## Operation
- The E register holds ra1E, ra2E, waE, resE and startE. startE is an internal 2-bit copy of mdD.
- On each clock edge without stall, the E register loads the D attributes. When stall=1, the E register loads all zeros, which is a bubble (resE=NW, waE=0, startE=0).
- A match on address r against write address w holds when r==w and w!=0.
- rs hazard (rt is identical, using ra2D/tuse2D):
  - resE=DM, match on waE, and tuse1D ∈ {0,1}
  - resE ∈ {ALU, MD}, match on waE, and tuse1D=0
  - resM=DM, match on waM, and tuse1D=0
- resE=PC, resM ∈ {ALU, MD, PC} and all NW entries never stall; these are resolved by forwarding.
- stall = rs hazard | rt hazard | (mduseD & busy).
- MDU counter cnt is 4 bits:
  - When startE=1, cnt loads MULT_CYC on the edge; when startE=2, it loads DIV_CYC. A load has priority over a decrement.
  - Otherwise, cnt decrements when it is nonzero.
- busy = (startE!=0) | (cnt!=0).
- If mdD is nonzero while stall=1, the start is not issued. It is issued only when the instruction actually enters E.

## Timing
- Reset values: ra1E=ra2E=waE=0, resE=0, startE=0, cnt=0. Outputs after reset: stall=0 (given inputs with no D hazard), busy=0.
- Attribute latency D→E is one cycle. An instruction stalled N cycles enters E N+1 edges after it first appears in D.
- Load-use with tuse=0 stalls 2 cycles (E-hit, then M-hit). With tuse=1 it stalls 1 cycle.
- Mult issue timeline: startE=1 in cycle t, cnt=5..1 in t+1..t+5, busy high t..t+5, low from t+6. Div is the same with 10, so busy is low from t+11.
- Reset asserted mid-stall or mid-MDU operation clears everything immediately, without waiting for an edge. busy and the MDU-caused stall fall in the same cycle.
- A simultaneous E and M hazard gives a single stall. Bubbles are never counted as instructions.

## Test plan
- Reset: rst=1 asynchronously mid-cycle with cnt=7 → all E outputs 0 and busy=0 before the next edge. After release, with no hazard, stall=0.
- Load-use: E holds lw $8 (resE=2, waE=8), D has addu with ra1D=8, tuse1D=0 → stall=1 for 2 cycles. Two bubbles enter E (resE=0), then addu enters E.
- Store-data: lw $9 in E, D has sw with ra2D=9, tuse2D=1 → stall 1 cycle. With resM=2/waM=9 the next cycle, stall=0.
- $0 immunity: lw $0 in E, D reads ra1D=0 with tuse1D=0 → stall=0.
- MDU: div issued (mdD=2), mflo in D the next cycle → stall=1 for 11 cycles, busy falls at t+11, and mflo enters E on the following edge.
- Non-MDU during busy: mult issued, then addu with mduseD=0 → stall=0 and cnt continues counting down 5..1.

Source files
------------

// File: rtl/atc_e_stage.sv
`default_nettype none
// ============================================================================
//  Module   : atc_e_stage
//  Purpose  : D->E attribute register, load-use / MDU hazard detection and
//             stall generation for the five-stage MIPS pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module atc_e_stage #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ra1D,
    input  logic [4:0] ra2D,
    input  logic [4:0] waD,
    input  logic [2:0] resD,
    input  logic [1:0] tuse1D,
    input  logic [1:0] tuse2D,
    input  logic [1:0] mdD,
    input  logic       mduseD,
    input  logic [4:0] waM,
    input  logic [2:0] resM,
    output logic [4:0] ra1E,
    output logic [4:0] ra2E,
    output logic [4:0] waE,
    output logic [2:0] resE,
    output logic       stall,
    output logic       busy
);

    localparam logic [2:0] c_RES_NW  = 3'd0;
    localparam logic [2:0] c_RES_ALU = 3'd1;
    localparam logic [2:0] c_RES_DM  = 3'd2;
    localparam logic [2:0] c_RES_MD  = 3'd4;

    localparam logic [1:0] c_MD_MULT = 2'd1;
    localparam logic [1:0] c_MD_DIV  = 2'd2;

    localparam logic [3:0] c_MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] c_DIV_LD  = 4'(DIV_CYC);

    logic [1:0] r_start;
    logic [3:0] r_cnt;
    logic       w_hz_rs;
    logic       w_hz_rt;
    logic       w_busy;

    // Writes to $0 never create a dependency.
    function automatic logic f_match(input logic [4:0] r, input logic [4:0] w);
        return (r == w) && (w != 5'd0);
    endfunction

    // Only hazards that forwarding cannot cover: loads in E/M, ALU/MD in E
    // against a same-cycle consumer. PC results and NW never stall.
    function automatic logic f_hazard(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] wa_e,
        input logic [2:0] res_e,
        input logic [4:0] wa_m,
        input logic [2:0] res_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = f_match(r, wa_e);
        hit_m = f_match(r, wa_m);
        return ((res_e == c_RES_DM) && hit_e && ((tuse == 2'd0) || (tuse == 2'd1)))
             | (((res_e == c_RES_ALU) || (res_e == c_RES_MD)) && hit_e && (tuse == 2'd0))
             | ((res_m == c_RES_DM) && hit_m && (tuse == 2'd0));
    endfunction

    always_comb begin
        w_hz_rs = f_hazard(ra1D, tuse1D, waE, resE, waM, resM);
        w_hz_rt = f_hazard(ra2D, tuse2D, waE, resE, waM, resM);
        w_busy  = (r_start != 2'd0) || (r_cnt != 4'd0);
    end

    assign busy  = w_busy;
    assign stall = w_hz_rs | w_hz_rt | (mduseD & w_busy);

    // A stalled cycle inserts a bubble, so a pending MDU start is dropped
    // until the instruction actually enters E.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra1E    <= 5'd0;
            ra2E    <= 5'd0;
            waE     <= 5'd0;
            resE    <= c_RES_NW;
            r_start <= 2'd0;
        end else if (stall) begin
            ra1E    <= 5'd0;
            ra2E    <= 5'd0;
            waE     <= 5'd0;
            resE    <= c_RES_NW;
            r_start <= 2'd0;
        end else begin
            ra1E    <= ra1D;
            ra2E    <= ra2D;
            waE     <= waD;
            resE    <= resD;
            r_start <= mdD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (r_start == c_MD_MULT) begin
            r_cnt <= c_MULT_LD;
        end else if (r_start == c_MD_DIV) begin
            r_cnt <= c_DIV_LD;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_atc_e_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_atc_e_stage
//  Purpose  : Directed scoreboard bench for atc_e_stage hazard/stall logic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_atc_e_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ra1D, ra2D, waD, waM;
    logic [2:0] resD, resM;
    logic [1:0] tuse1D, tuse2D, mdD;
    logic       mduseD;
    logic [4:0] ra1E, ra2E, waE;
    logic [2:0] resE;
    logic       stall, busy;

    int total = 0;
    int bad   = 0;
    logic [17:0] sb_q[$];

    atc_e_stage #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .rst(rst),
        .ra1D(ra1D), .ra2D(ra2D), .waD(waD), .resD(resD),
        .tuse1D(tuse1D), .tuse2D(tuse2D), .mdD(mdD), .mduseD(mduseD),
        .waM(waM), .resM(resM),
        .ra1E(ra1E), .ra2E(ra2E), .waE(waE), .resE(resE),
        .stall(stall), .busy(busy)
    );

    always #5 clk = ~clk;

    // Downstream E->M attribute register
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            waM  <= 5'd0;
            resM <= 3'd0;
        end else begin
            waM  <= waE;
            resM <= resE;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w,
                       input logic [2:0] res, input logic [1:0] t1, input logic [1:0] t2,
                       input logic [1:0] md, input logic mu);
        ra1D = r1; ra2D = r2; waD = w; resD = res;
        tuse1D = t1; tuse2D = t2; mdD = md; mduseD = mu;
    endtask

    task automatic idle();
        drv(5'd0, 5'd0, 5'd0, 3'd0, 2'd3, 2'd3, 2'd0, 1'b0);
    endtask

    // One pipeline cycle: check comb outputs, predict what E will hold, clock, compare.
    task automatic cyc(input string tag, input logic es, input logic eb);
        logic [17:0] exp_e;
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'(es));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        sb_q.push_back(es ? 18'd0 : {ra1D, ra2D, waD, resD});
        @(posedge clk);
        #1;
        exp_e = sb_q.pop_front();
        chk({tag, ".E"}, 32'({ra1E, ra2E, waE, resE}), 32'(exp_e));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.E", 32'({ra1E, ra2E, waE, resE}), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);

        // Load-use, tuse=0: two-cycle stall
        drv(5'd29, 5'd0, 5'd8, 3'd2, 2'd1, 2'd3, 2'd0, 1'b0);
        cyc("lw8", 1'b0, 1'b0);
        drv(5'd8, 5'd10, 5'd11, 3'd1, 2'd0, 2'd0, 2'd0, 1'b0);
        cyc("lu.e", 1'b1, 1'b0);
        cyc("lu.m", 1'b1, 1'b0);
        cyc("lu.go", 1'b0, 1'b0);

        // Store data, tuse=1: one-cycle stall, M load does not stall
        drv(5'd29, 5'd0, 5'd9, 3'd2, 2'd1, 2'd3, 2'd0, 1'b0);
        cyc("lw9", 1'b0, 1'b0);
        drv(5'd29, 5'd9, 5'd0, 3'd0, 2'd1, 2'd1, 2'd0, 1'b0);
        cyc("sw.e", 1'b1, 1'b0);
        chk("sw.resM", 32'(resM), 32'd2);
        cyc("sw.go", 1'b0, 1'b0);

        // $0 destination never matches
        drv(5'd29, 5'd0, 5'd0, 3'd2, 2'd1, 2'd3, 2'd0, 1'b0);
        cyc("lw0", 1'b0, 1'b0);
        drv(5'd0, 5'd0, 5'd12, 3'd1, 2'd0, 2'd0, 2'd0, 1'b0);
        cyc("zero", 1'b0, 1'b0);

        // ALU in E with tuse=0 stalls once; ALU in M forwards
        drv(5'd1, 5'd2, 5'd13, 3'd1, 2'd0, 2'd0, 2'd0, 1'b0);
        cyc("add13", 1'b0, 1'b0);
        drv(5'd13, 5'd0, 5'd0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        cyc("beq.e", 1'b1, 1'b0);
        cyc("beq.m", 1'b0, 1'b0);

        // PC result in E forwards
        drv(5'd0, 5'd0, 5'd31, 3'd3, 2'd3, 2'd3, 2'd0, 1'b0);
        cyc("jal", 1'b0, 1'b0);
        drv(5'd31, 5'd0, 5'd0, 3'd0, 2'd0, 2'd3, 2'd0, 1'b0);
        cyc("jr", 1'b0, 1'b0);

        // Divide then mflo: 11 stall cycles
        drv(5'd4, 5'd5, 5'd0, 3'd0, 2'd1, 2'd1, 2'd2, 1'b1);
        cyc("div", 1'b0, 1'b0);
        drv(5'd0, 5'd0, 5'd2, 3'd4, 2'd3, 2'd3, 2'd0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            cyc($sformatf("mflo.%0d", i), 1'b1, 1'b1);
        end
        chk("div.cnt0", 32'(dut.r_cnt), 32'd0);
        cyc("mflo.go", 1'b0, 1'b0);

        // Multiply, independent instruction proceeds while counting
        drv(5'd6, 5'd7, 5'd0, 3'd0, 2'd1, 2'd1, 2'd1, 1'b1);
        cyc("mult", 1'b0, 1'b0);
        drv(5'd8, 5'd9, 5'd10, 3'd1, 2'd0, 2'd0, 2'd0, 1'b0);
        cyc("mul.add", 1'b0, 1'b1);
        idle();
        for (int k = 5; k >= 1; k--) begin
            chk($sformatf("mul.cnt%0d", k), 32'(dut.r_cnt), 32'(k));
            cyc($sformatf("mul.idle%0d", k), 1'b0, 1'b1);
        end
        chk("mul.cntend", 32'(dut.r_cnt), 32'd0);
        cyc("mul.done", 1'b0, 1'b0);

        // Asynchronous reset in the middle of a divide
        drv(5'd4, 5'd5, 5'd0, 3'd0, 2'd1, 2'd1, 2'd2, 1'b1);
        cyc("div2", 1'b0, 1'b0);
        drv(5'd0, 5'd0, 5'd2, 3'd4, 2'd3, 2'd3, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("mflo2.%0d", i), 1'b1, 1'b1);
        end
        chk("ar.cnt7", 32'(dut.r_cnt), 32'd7);
        #1;
        rst = 1'b1;
        #1;
        chk("ar.E", 32'({ra1E, ra2E, waE, resE}), 32'd0);
        chk("ar.busy", 32'(busy), 32'd0);
        chk("ar.stall", 32'(stall), 32'd0);
        chk("ar.cnt", 32'(dut.r_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        cyc("post", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
